// File: rtl/gpio_cond_pkg.sv
// Shared types, limits and sizing helper for the GPIO input conditioner.
package gpio_cond_pkg;

  // Per-channel event mode, encoded as {fall_enable, rise_enable}.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int MAX_CH = 32;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce.sv
// One GPIO channel: 2-flop synchroniser, stability counter, debounced
// level and single-cycle rise/fall pulses registered with the level update.
module debounce_channel
  import gpio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next-state: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples disagree with the current level.
  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-channel debounce/edge detect, sticky pending
// flags with software clear, and a registered level interrupt request.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     gpio_in,
  input  logic [2*NUM_CH-1:0]   edge_sel,
  input  logic [NUM_CH-1:0]     irq_en,
  input  logic                  clr_valid,
  input  logic [NUM_CH-1:0]     clr_mask,
  output logic [NUM_CH-1:0]     level_out,
  output logic [NUM_CH-1:0]     rise_pulse,
  output logic [NUM_CH-1:0]     fall_pulse,
  output logic [NUM_CH-1:0]     pending,
  output logic                  irq
);

  logic [NUM_CH-1:0] event_vec;
  logic [NUM_CH-1:0] clr_bits;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              irq_q, irq_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    edge_mode_t mode;

    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .din     (gpio_in[gi]),
      .level_o (level_out[gi]),
      .rise_o  (rise_pulse[gi]),
      .fall_o  (fall_pulse[gi])
    );

    // Event qualification from the registered pulses and the current mode.
    assign mode = edge_mode_t'(edge_sel[2*gi +: 2]);
    assign event_vec[gi] =
        (rise_pulse[gi] && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
        (fall_pulse[gi] && (mode == EDGE_FALL || mode == EDGE_BOTH));
  end

  // Pending update: clear first, then OR in new events so a colliding
  // event is never lost; irq summarises the previous pending state.
  always_comb begin
    clr_bits  = clr_valid ? clr_mask : '0;
    pending_d = (pending_q & ~clr_bits) | event_vec;
    irq_d     = |(pending_q & irq_en);
  end

  // Pending and irq registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign pending = pending_q;
  assign irq     = irq_q;

endmodule
